// File: rtl/riscv_hwloop_pkg.sv
// Shared hardware-loop types and constants.
// Used by the jump controller and its match logic.
package riscv_hwloop_pkg;

  typedef enum logic [1:0] {
    HWLP_IDLE,
    HWLP_JUMP,
    HWLP_SETTLE
  } hwlp_state_e;

  localparam int HWLP_WE_START = 0;
  localparam int HWLP_WE_END   = 1;
  localparam int HWLP_WE_CNT   = 2;

endpackage

// File: rtl/riscv_hwloop_jump_ctrl_if.sv
// Jump request handshake between the loop controller
// and the fetch unit.
interface riscv_hwloop_jump_ctrl_if;

  logic        jump_o;
  logic [31:0] jump_target_o;
  logic        jump_ack_i;

  modport master (
    output jump_o,
    output jump_target_o,
    input  jump_ack_i
  );

  modport slave (
    input  jump_o,
    input  jump_target_o,
    output jump_ack_i
  );

endinterface

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-address compare with lowest-index
// priority select; loop 0 is the innermost loop.
module riscv_hwloop_match #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic [31:0]                   pc_i,
  input  logic                          pc_valid_i,
  input  logic                          flush_i,
  input  logic [N_REGS-1:0][31:0]       hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0]       hwlp_counter_i,
  output logic                          hit_o,
  output logic [N_REG_BITS-1:0]         idx_o,
  output logic                          last_o
);

  logic [N_REGS-1:0] hit_vec;

  // A zero counter marks an inactive loop.
  always_comb begin
    hit_vec = '0;
    for (int k = 0; k < N_REGS; k++) begin
      hit_vec[k] = pc_valid_i & ~flush_i &
                   (pc_i == hwlp_end_addr_i[k]) &
                   (hwlp_counter_i[k] != 32'd0);
    end
  end

  // Scan high to low so the lowest hit wins.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    last_o = 1'b0;
    for (int k = N_REGS - 1; k >= 0; k--) begin
      if (hit_vec[k]) begin
        hit_o  = 1'b1;
        idx_o  = N_REG_BITS'(k);
        last_o = (hwlp_counter_i[k] == 32'd1);
      end
    end
  end

endmodule

// File: rtl/riscv_hwloop_jump_ctrl.sv
// Hardware-loop jump controller: detects loop ends,
// requests the jump back and the counter decrement.
module riscv_hwloop_jump_ctrl
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             pc_i,
  input  logic                    pc_valid_i,
  input  logic                    flush_i,
  input  logic [N_REGS-1:0][31:0] hwlp_start_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_end_addr_i,
  input  logic [N_REGS-1:0][31:0] hwlp_counter_i,
  input  logic [2:0]              hwlp_we_i,
  input  logic [N_REG_BITS-1:0]   hwlp_regid_i,
  riscv_hwloop_jump_ctrl_if.master jmp,
  output logic [N_REGS-1:0]       hwlp_dec_cnt_o,
  output logic                    dec_valid_o,
  output logic                    busy_o
);

  hwlp_state_e           state_q;
  logic [N_REG_BITS-1:0] idx_q;
  logic                  hit;
  logic [N_REG_BITS-1:0] hit_idx;
  logic                  hit_last;
  logic                  wr_idx;

  riscv_hwloop_match #(
    .N_REGS     (N_REGS),
    .N_REG_BITS (N_REG_BITS)
  ) u_match (
    .pc_i            (pc_i),
    .pc_valid_i      (pc_valid_i),
    .flush_i         (flush_i),
    .hwlp_end_addr_i (hwlp_end_addr_i),
    .hwlp_counter_i  (hwlp_counter_i),
    .hit_o           (hit),
    .idx_o           (hit_idx),
    .last_o          (hit_last)
  );

  // A reg-file write to the active loop voids the jump.
  always_comb begin
    wr_idx = (hwlp_we_i[HWLP_WE_START] |
              hwlp_we_i[HWLP_WE_END] |
              hwlp_we_i[HWLP_WE_CNT]) &
             (hwlp_regid_i == idx_q);
  end

  // Loop FSM with registered jump/decrement outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= HWLP_IDLE;
      idx_q             <= '0;
      jmp.jump_o        <= 1'b0;
      jmp.jump_target_o <= '0;
      hwlp_dec_cnt_o    <= '0;
      dec_valid_o       <= 1'b0;
      busy_o            <= 1'b0;
    end else begin
      hwlp_dec_cnt_o <= '0;
      dec_valid_o    <= 1'b0;
      unique case (state_q)
        HWLP_IDLE: begin
          if (hit) begin
            idx_q             <= hit_idx;
            jmp.jump_target_o <= hwlp_start_addr_i[hit_idx];
            hwlp_dec_cnt_o    <= N_REGS'(1) << hit_idx;
            dec_valid_o       <= 1'b1;
            busy_o            <= 1'b1;
            if (hit_last) begin
              state_q    <= HWLP_SETTLE;
              jmp.jump_o <= 1'b0;
            end else begin
              state_q    <= HWLP_JUMP;
              jmp.jump_o <= 1'b1;
            end
          end
        end
        HWLP_JUMP: begin
          if (flush_i || wr_idx) begin
            state_q    <= HWLP_IDLE;
            jmp.jump_o <= 1'b0;
            busy_o     <= 1'b0;
          end else if (jmp.jump_ack_i) begin
            state_q    <= HWLP_SETTLE;
            jmp.jump_o <= 1'b0;
          end
        end
        HWLP_SETTLE: begin
          state_q <= HWLP_IDLE;
          busy_o  <= 1'b0;
        end
        default: begin
          state_q    <= HWLP_IDLE;
          jmp.jump_o <= 1'b0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_hwloop_jump_ctrl.sv
// Bench for the hardware-loop jump controller:
// vector table, corner sequences, random vs model.
module tb_riscv_hwloop_jump_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       pc;
  logic              pc_valid;
  logic              flush;
  logic [1:0][31:0]  st, en, cn;
  logic [2:0]        we;
  logic              regid;
  logic [1:0]        dec;
  logic              dec_valid;
  logic              busy;

  riscv_hwloop_jump_ctrl_if jif ();

  riscv_hwloop_jump_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_i              (pc),
    .pc_valid_i        (pc_valid),
    .flush_i           (flush),
    .hwlp_start_addr_i (st),
    .hwlp_end_addr_i   (en),
    .hwlp_counter_i    (cn),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .jmp               (jif),
    .hwlp_dec_cnt_o    (dec),
    .dec_valid_o       (dec_valid),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string n, input logic ej,
                         input logic [31:0] et,
                         input logic [1:0] ed,
                         input logic ev, input logic eb);
    chk({n, "_jump"}, 32'(jif.jump_o), 32'(ej));
    chk({n, "_tgt"}, jif.jump_target_o, et);
    chk({n, "_dec"}, 32'(dec), 32'(ed));
    chk({n, "_decv"}, 32'(dec_valid), 32'(ev));
    chk({n, "_busy"}, 32'(busy), 32'(eb));
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        vld, fl, ack;
    logic [2:0]  we;
    logic        rid;
    logic [31:0] c0;
    logic        ej;
    logic [31:0] et;
    logic [1:0]  ed;
    logic        ev, eb;
  } vec_t;

  function automatic vec_t mk(
    logic [31:0] p, logic v, logic f, logic a,
    logic [2:0] w, logic r, logic [31:0] c,
    logic ej, logic [31:0] et, logic [1:0] ed,
    logic ev, logic eb);
    vec_t x;
    x.pc = p; x.vld = v; x.fl = f; x.ack = a;
    x.we = w; x.rid = r; x.c0 = c;
    x.ej = ej; x.et = et; x.ed = ed;
    x.ev = ev; x.eb = eb;
    return x;
  endfunction

  // Behavioural model: phase 0 waiting for a loop end,
  // 1 jump outstanding, 2 one-cycle cool-down.
  int          m_ph;
  int          m_idx;
  logic        m_jump;
  logic [31:0] m_tgt;
  logic [1:0]  m_dec;
  logic        m_decv, m_busy;

  task automatic model_reset();
    m_ph = 0; m_idx = 0; m_jump = 0; m_tgt = 0;
    m_dec = 0; m_decv = 0; m_busy = 0;
  endtask

  task automatic model_step();
    int sel;
    m_dec = 0;
    m_decv = 0;
    if (m_ph == 0) begin
      sel = -1;
      for (int k = 1; k >= 0; k--)
        if (pc_valid && !flush && pc == en[k] && cn[k] != 0)
          sel = k;
      if (sel >= 0) begin
        m_idx = sel;
        m_tgt = st[sel];
        m_dec = 2'(1 << sel);
        m_decv = 1;
        m_jump = (cn[sel] >= 2);
        m_ph = m_jump ? 1 : 2;
      end
    end else if (m_ph == 1) begin
      if (flush || (we != 0 && int'(regid) == m_idx)) begin
        m_jump = 0;
        m_ph = 0;
      end else if (jif.jump_ack_i) begin
        m_jump = 0;
        m_ph = 2;
      end
    end else begin
      m_ph = 0;
    end
    m_busy = (m_ph != 0);
  endtask

  vec_t tbl[16];

  initial begin
    int ndec, first, second, pend;
    logic [1:0][31:0] nst, nen, ncn;
    logic [31:0] wv;

    rst_n = 0; pc = 0; pc_valid = 0; flush = 0;
    st = '0; en = '0; cn = '0; we = 0; regid = 0;
    jif.jump_ack_i = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;

    // Vector table: loop0 0x100..0x120, loop1 idle.
    tbl[0]  = mk('h120,1,0,0,0,0,3, 1,'h100,1,1,1);
    tbl[1]  = mk('h124,1,0,1,0,0,2, 0,'h100,0,0,1);
    tbl[2]  = mk('h100,1,0,0,0,0,2, 0,'h100,0,0,0);
    tbl[3]  = mk('h120,1,0,0,0,0,2, 1,'h100,1,1,1);
    tbl[4]  = mk('h124,1,0,1,0,0,1, 0,'h100,0,0,1);
    tbl[5]  = mk('h100,1,0,0,0,0,1, 0,'h100,0,0,0);
    tbl[6]  = mk('h120,1,0,0,0,0,1, 0,'h100,1,1,1);
    tbl[7]  = mk('h124,1,0,0,0,0,0, 0,'h100,0,0,0);
    tbl[8]  = mk('h120,1,0,0,0,0,0, 0,'h100,0,0,0);
    tbl[9]  = mk('h120,1,1,0,0,0,3, 0,'h100,0,0,0);
    tbl[10] = mk('h120,0,0,0,0,0,3, 0,'h100,0,0,0);
    tbl[11] = mk('h120,1,0,0,0,0,3, 1,'h100,1,1,1);
    tbl[12] = mk('h124,1,1,1,0,0,2, 0,'h100,0,0,0);
    tbl[13] = mk('h120,1,0,0,4,0,3, 1,'h100,1,1,1);
    tbl[14] = mk('h124,1,0,0,4,1,2, 1,'h100,0,0,1);
    tbl[15] = mk('h124,1,0,1,4,0,2, 0,'h100,0,0,0);
    st[0] = 'h100; en[0] = 'h120;
    st[1] = 'h400; en[1] = 'h500; cn[1] = 0;
    for (int i = 0; i < 16; i++) begin
      pc = tbl[i].pc; pc_valid = tbl[i].vld;
      flush = tbl[i].fl; jif.jump_ack_i = tbl[i].ack;
      we = tbl[i].we; regid = tbl[i].rid;
      cn[0] = tbl[i].c0;
      tick();
      chk_all($sformatf("tbl%0d", i), tbl[i].ej,
              tbl[i].et, tbl[i].ed, tbl[i].ev, tbl[i].eb);
    end
    we = 0; flush = 0; jif.jump_ack_i = 0; pc = 0;
    tick();

    // Both loops end at 0x200: loop 0 wins.
    st[0] = 'h180; st[1] = 'h1c0;
    en[0] = 'h200; en[1] = 'h200;
    cn[0] = 5; cn[1] = 2; pc = 'h200;
    tick();
    chk_all("prio", 1, 'h180, 2'b01, 1, 1);
    jif.jump_ack_i = 1; pc = 'h204;
    tick();
    tick();
    jif.jump_ack_i = 0;
    chk("prio_idle", 32'(busy), 0);

    // Ack held off 5 cycles: request must stay stable.
    st[0] = 'h100; en[0] = 'h120; cn[0] = 4; cn[1] = 0;
    pc = 'h120;
    tick();
    pc = 'h124;
    for (int i = 0; i < 5; i++) begin
      chk_all($sformatf("hold%0d", i), 1, 'h100,
              i == 0 ? 2'b01 : 2'b00, i == 0, 1);
      tick();
    end
    jif.jump_ack_i = 1;
    tick();
    jif.jump_ack_i = 0;
    chk_all("hold_ack", 0, 'h100, 0, 0, 1);
    tick();
    chk("hold_idle", 32'(busy), 0);

    // Single-instruction body, counter fed back.
    st[0] = 'h300; en[0] = 'h300; cn[0] = 2;
    pc = 'h300; jif.jump_ack_i = 1;
    ndec = 0; first = -1; second = -1; pend = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (pend != 0) cn[0] = cn[0] - 1;
      pend = int'(dec_valid & dec[0]);
      if (dec_valid) begin
        ndec++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk("single_ndec", 32'(ndec), 2);
    chk("single_gap", 32'(second - first), 3);
    chk("single_cnt", cn[0], 0);
    jif.jump_ack_i = 0; pc = 0;
    tick();

    // Flush while the jump is outstanding.
    st[0] = 'h100; en[0] = 'h120; cn[0] = 3; pc = 'h120;
    tick();
    chk_all("fl_hit", 1, 'h100, 2'b01, 1, 1);
    flush = 1; pc = 'h124;
    tick();
    flush = 0;
    chk_all("fl_drop", 0, 'h100, 0, 0, 0);

    // Asynchronous reset in the middle of a jump.
    pc = 'h120;
    tick();
    chk("rst_pre", 32'(jif.jump_o), 1);
    #2 rst_n = 0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    pc = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("rst_post%0d", i), 0, 0, 0, 0, 0);
    end

    // Randomised run against the model with a modelled
    // reg file (write beats decrement).
    rst_n = 0; #2; rst_n = 1;
    model_reset();
    st[0] = 'h100; en[0] = 'h120; cn[0] = 3;
    st[1] = 'h110; en[1] = 'h140; cn[1] = 2;
    @(negedge clk);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: pc = en[0];
        1: pc = en[1];
        2: pc = 'h124;
        default: pc = $urandom_range(0, 'h3ff) & ~32'h3;
      endcase
      pc_valid = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      jif.jump_ack_i = $urandom_range(0, 1) == 1;
      we = ($urandom_range(0, 19) == 0) ?
           3'(1 << $urandom_range(0, 2)) : 3'b000;
      regid = $urandom_range(0, 1) == 1;
      nst = st; nen = en; ncn = cn;
      if (m_decv)
        for (int k = 0; k < 2; k++)
          if (m_dec[k] && cn[k] != 0) ncn[k] = cn[k] - 1;
      wv = $urandom_range(0, 4);
      if (we[0]) nst[regid] = wv[0] ? 'h100 : 'h110;
      if (we[1]) nen[regid] = wv[1] ? 'h120 : 'h140;
      if (we[2]) ncn[regid] = wv;
      model_step();
      tick();
      st = nst; en = nen; cn = ncn;
      chk_all("rnd", m_jump, m_tgt, m_dec, m_decv, m_busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
